pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline register for the RISC-V core, used between IF/ID/EX/MEM/WB.
//  Adds to the plain stalled register: a valid/ready handshake, a flush input, and an optional
//  2-entry skid buffer so upstream ready is a registered signal. Also keeps a saturating
//  stall-cycle counter. Payload is an opaque DATA_W bus (opcode/regs/imm/wd/wreg packed by caller).
// PARAMETERS
//  DATA_W     64        payload width in bits
//  SKID       1         1: 2-entry skid buffer, registered in_ready; 0: single register, combinational in_ready
//  STALL_W    6         width of ctrl stall vector
//  STALL_BIT  3         index of stall_sign bit that holds this stage
//  NOP_VAL    0         payload value loaded on reset/flush (bubble encoding)
//  CNT_W      16        width of stall counter
// PORTS
//  clk         in   1        clock, rising edge
//  rst         in   1        synchronous, active-high reset (`RstEnable = 1)
//  stall_sign  in   STALL_W  ctrl stall vector; bit STALL_BIT holds this stage
//  flush       in   1        kill all held entries (branch/jump redirect)
//  in_valid    in   1        upstream payload valid
//  in_ready    out  1        stage can accept in_data this cycle
//  in_data     in   DATA_W   upstream payload
//  out_valid   out  1        out_data holds a live instruction
//  out_ready   in   1        downstream accepts out_data this cycle
//  out_data    out  DATA_W   payload to next stage (main register)
//  stall_cnt   out  CNT_W    cycles with out_valid=1 and hold=1, saturating
// BEHAVIOUR
//  Definitions: hold = stall_sign[STALL_BIT] | ~out_ready; out_fire = out_valid & ~hold;
//   in_fire = in_valid & in_ready & ~flush.
//  Reset (rst=1 at clk edge): out_valid=0, out_data=NOP_VAL, skid empty, stall_cnt=0;
//   in_ready=1 in the cycle after reset (SKID=1). rst has priority over flush and all inputs.
//  Latency: 1 cycle from in_fire to out_valid/out_data when the stage is empty.
//  States (SKID=1): EMPTY (no entry), ONE (main valid), FULL (main + skid valid).
//   EMPTY: in_fire -> ONE, main<=in_data.
//   ONE:   in_fire&out_fire -> ONE, main<=in_data; in_fire&~out_fire -> FULL, skid<=in_data;
//          ~in_fire&out_fire -> EMPTY, main<=NOP_VAL; else stay.
//   FULL:  out_fire -> ONE, main<=skid; else stay. in_fire is impossible in FULL.
//  in_ready (SKID=1) is a register: 1 in EMPTY/ONE, 0 in FULL. No combinational in->out path.
//  SKID=0: FULL is unreachable; in_ready = ~out_valid | out_fire (combinational).
//   in_fire&~out_fire while ONE cannot occur.
//  Order is strict FIFO: skid entry is always emitted before any later input.
//  Flush: next edge forces EMPTY, out_valid=0, main=NOP_VAL, skid discarded.
//   Same-cycle in_valid is dropped (in_fire masked). Any out_fire in that cycle still counts
//   as consumed downstream.
//  Stall with data held: main and skid are frozen; out_data stays stable while out_valid&hold.
//  out_data when out_valid=0 is NOP_VAL.
//  stall_cnt: +1 each cycle with out_valid&hold, sticks at 2^CNT_W-1. Cleared only by rst,
//   not by flush.
//  rst asserted mid-transfer: all entries lost, no partial update.
// TESTING
//  1 reset: rst=1 for 2 cycles with in_valid=1, in_data=0xAA -> out_valid=0, out_data=NOP_VAL,
//    stall_cnt=0, in_ready=1 after release.
//  2 stream: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1, no stall ->
//    out_data 1,2,3,4 one cycle later each, out_valid=1 continuous.
//  3 skid: send 0x11; stall_sign[3]=1 during the next cycle while 0x22 arrives ->
//    FULL, in_ready=0, out_data=0x11 held; release -> 0x11 out, then 0x22; stall_cnt=1.
//  4 flush: FULL with 0x33/0x44, flush=1 with in_valid=1, in_data=0x55 -> next cycle
//    out_valid=0, out_data=NOP_VAL, 0x55 never appears, in_ready=1.
//  5 backpressure/saturation: CNT_W=4, out_ready=0 for 20 cycles with a valid entry ->
//    stall_cnt=15, out_data unchanged.
//  6 SKID=0 build: repeat scenario 3 -> 0x22 is not accepted (in_ready=0) until 0x11 fires;
//    order 0x11, 0x22.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, flush, optional 2-entry skid
// buffer and a saturating stall-cycle counter. Payload is opaque to this block.
module pipe_stage_buf #(
  parameter int                DATA_W    = 64,
  parameter int                SKID      = 1,
  parameter int                STALL_W   = 6,
  parameter int                STALL_BIT = 3,
  parameter logic [DATA_W-1:0] NOP_VAL   = '0,
  parameter int                CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall_sign,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [1:0]         dbg_state
);

  // Handshake: a beat moves on a port when its valid and ready are both high at the
  // rising edge. Upstream data is taken only when in_valid & in_ready & ~flush; the
  // main register is released downstream when out_valid & ~hold.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [DATA_W-1:0]   r_main;
  logic [DATA_W-1:0]   r_skid;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_hold;
  logic                w_out_fire;
  logic                w_in_ready;
  logic                w_in_fire;
  logic                w_cnt_sat;

  always_comb begin
    w_hold     = stall_sign[STALL_BIT] | ~out_ready;
    w_out_fire = r_out_valid & ~w_hold;
    // Without the skid entry the stage can only accept when its single slot frees up.
    w_in_ready = (SKID != 0) ? r_in_ready : (~r_out_valid | w_out_fire);
    w_in_fire  = in_valid & w_in_ready & ~flush;
    w_cnt_sat  = &r_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_main      <= NOP_VAL;
      r_skid      <= NOP_VAL;
      r_cnt       <= '0;
    end else begin
      if (r_out_valid && w_hold && !w_cnt_sat)
        r_cnt <= r_cnt + 1'b1;

      if (flush) begin
        r_state     <= ST_EMPTY;
        r_out_valid <= 1'b0;
        r_in_ready  <= 1'b1;
        r_main      <= NOP_VAL;
        r_skid      <= NOP_VAL;
      end else begin
        case (r_state)
          ST_EMPTY: begin
            if (w_in_fire) begin
              r_state     <= ST_ONE;
              r_out_valid <= 1'b1;
              r_main      <= in_data;
            end
          end
          ST_ONE: begin
            if (w_in_fire && w_out_fire) begin
              r_main <= in_data;
            end else if (w_in_fire) begin
              // Only reachable with the skid buffer: park the new beat behind main.
              r_state    <= ST_FULL;
              r_skid     <= in_data;
              r_in_ready <= 1'b0;
            end else if (w_out_fire) begin
              r_state     <= ST_EMPTY;
              r_out_valid <= 1'b0;
              r_main      <= NOP_VAL;
            end
          end
          ST_FULL: begin
            if (w_out_fire) begin
              r_state    <= ST_ONE;
              r_main     <= r_skid;
              r_skid     <= NOP_VAL;
              r_in_ready <= 1'b1;
            end
          end
          default: begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main      <= NOP_VAL;
            r_skid      <= NOP_VAL;
          end
        endcase
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign stall_cnt = r_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: a skid build (small counter, non-zero bubble) and a no-skid
// build, driven by directed scenarios with a per-instance expected-output queue.
module tb_pipe_stage_buf;

  localparam int DW = 64;
  localparam logic [DW-1:0] NOP_A = 64'h13;

  logic clk;
  int   checks   = 0;
  int   failures = 0;

  // Instance A: SKID=1, CNT_W=4, NOP_VAL=0x13
  logic          a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [5:0]    a_stall;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [3:0]    a_cnt;
  logic [1:0]    a_state;
  // Instance B: SKID=0, default counter, NOP_VAL=0
  logic          b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [5:0]    b_stall;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [15:0]   b_cnt;
  logic [1:0]    b_state;

  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];

  pipe_stage_buf #(.DATA_W(DW), .SKID(1), .STALL_W(6), .STALL_BIT(3),
                   .NOP_VAL(NOP_A), .CNT_W(4)) dut_a (
    .clk(clk), .rst(a_rst), .stall_sign(a_stall), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall_cnt(a_cnt), .dbg_state(a_state)
  );

  pipe_stage_buf #(.DATA_W(DW), .SKID(0), .STALL_W(6), .STALL_BIT(3),
                   .NOP_VAL('0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(b_rst), .stall_sign(b_stall), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall_cnt(b_cnt), .dbg_state(b_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    a_in_valid = 1'b0; a_in_data = '0; a_flush = 1'b0;
    a_stall = '0; a_out_ready = 1'b1;
  endtask

  task automatic reset_a();
    a_rst = 1'b1;
    cyc(2);
    a_rst = 1'b0;
  endtask

  task automatic send_a(input logic [DW-1:0] d);
    a_in_valid = 1'b1;
    a_in_data  = d;
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!a_rst && a_out_valid && a_out_ready && !a_stall[3]) begin
      checks++;
      if (exp_a.size() == 0) begin
        failures++;
        $display("FAIL a_unexpected_out: got %0h expected none", a_out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_a.pop_front();
        if (a_out_data !== e) begin
          failures++;
          $display("FAIL a_out_data: got %0h expected %0h", a_out_data, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!b_rst && b_out_valid && b_out_ready && !b_stall[3]) begin
      checks++;
      if (exp_b.size() == 0) begin
        failures++;
        $display("FAIL b_unexpected_out: got %0h expected none", b_out_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_b.pop_front();
        if (b_out_data !== e) begin
          failures++;
          $display("FAIL b_out_data: got %0h expected %0h", b_out_data, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_a();
    b_in_valid = 1'b0; b_in_data = '0; b_flush = 1'b0; b_stall = '0; b_out_ready = 1'b1;

    // 1: reset with live input must leave the stage empty
    a_rst = 1'b1; b_rst = 1'b1;
    send_a(64'hAA);
    b_in_valid = 1'b1; b_in_data = 64'hAA;
    cyc(2);
    a_rst = 1'b0; b_rst = 1'b0;
    idle_a();
    b_in_valid = 1'b0;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data", a_out_data, NOP_A);
    chk("rst_stall_cnt", a_cnt, 4'd0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_state", a_state, 2'd0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);

    // 2: streaming 1..4; stall bits other than bit 3 must not hold the stage
    a_stall = 6'b110111;
    for (int i = 1; i <= 4; i++) exp_a.push_back(DW'(i));
    for (int i = 1; i <= 4; i++) begin
      send_a(DW'(i));
      cyc();
      chk("stream_valid", a_out_valid, 1'b1);
      chk("stream_data", a_out_data, DW'(i));
    end
    idle_a();
    cyc();
    chk("stream_drain_valid", a_out_valid, 1'b0);
    chk("stream_drain_data", a_out_data, NOP_A);

    // 3: skid fill under stall, then drain in order
    reset_a();
    exp_a.push_back(64'h11);
    exp_a.push_back(64'h22);
    send_a(64'h11);
    cyc();
    a_stall = 6'b001000;
    send_a(64'h22);
    cyc();
    chk("skid_in_ready", a_in_ready, 1'b0);
    chk("skid_state_full", a_state, 2'd2);
    chk("skid_hold_data", a_out_data, 64'h11);
    idle_a();
    cyc();
    chk("skid_second", a_out_data, 64'h22);
    chk("skid_in_ready_back", a_in_ready, 1'b1);
    cyc();
    chk("skid_empty", a_out_valid, 1'b0);
    chk("skid_stall_cnt", a_cnt, 4'd1);

    // 4: flush a full stage while a new beat is offered
    reset_a();
    send_a(64'h33);
    cyc();
    a_stall = 6'b001000;
    send_a(64'h44);
    cyc();
    a_flush = 1'b1;
    send_a(64'h55);
    cyc();
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_out_data", a_out_data, NOP_A);
    chk("flush_in_ready", a_in_ready, 1'b1);
    chk("flush_keeps_cnt", a_cnt, 4'd2);
    idle_a();
    cyc(3);
    chk("flush_no_55", a_out_valid, 1'b0);

    // 5: backpressure saturates the 4-bit counter
    reset_a();
    exp_a.push_back(64'h77);
    send_a(64'h77);
    cyc();
    idle_a();
    a_out_ready = 1'b0;
    cyc(14);
    chk("sat_cnt_14", a_cnt, 4'd14);
    cyc(6);
    chk("sat_cnt_15", a_cnt, 4'd15);
    chk("sat_data", a_out_data, 64'h77);
    chk("sat_valid", a_out_valid, 1'b1);
    a_out_ready = 1'b1;
    cyc();
    chk("sat_drained", a_out_valid, 1'b0);
    chk("sat_cnt_kept", a_cnt, 4'd15);

    // 6: no-skid build refuses the second beat until the first leaves
    exp_b.push_back(64'h11);
    exp_b.push_back(64'h22);
    b_in_valid = 1'b1; b_in_data = 64'h11;
    cyc();
    b_stall = 6'b001000;
    b_in_data = 64'h22;
    #1;
    chk("noskid_ready_low", b_in_ready, 1'b0);
    cyc();
    chk("noskid_held", b_out_data, 64'h11);
    chk("noskid_state_one", b_state, 2'd1);
    b_stall = '0;
    #1;
    chk("noskid_ready_fire", b_in_ready, 1'b1);
    cyc();
    b_in_valid = 1'b0;
    chk("noskid_second", b_out_data, 64'h22);
    cyc();
    chk("noskid_empty", b_out_valid, 1'b0);
    chk("noskid_cnt", b_cnt, 16'd1);

    cyc(2);
    chk("a_queue_drained", DW'(exp_a.size()), '0);
    chk("b_queue_drained", DW'(exp_b.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
